// File: rtl/pc_sequencer.sv
// pc_sequencer: registered next-PC unit with branch/jump/return/exception redirect, stall, bubbles and a circular RAS
// Ports: Clk/Rst_n clock and async active-low reset; Stall holds PC, Valid and RAS;
//   BranchTaken/BranchTarget, Jump/JumpTarget, Call/Return (qualify Jump), Exception redirect inputs;
//   PC fetch address, PCAddResult = PC + INC, Valid (0 = bubble), Misaligned (target low bits dropped),
//   RasEmpty/RasFull return-address stack occupancy flags.
module pc_sequencer #(
    parameter int               WIDTH      = 32,
    parameter int               INC        = 4,
    parameter int               ALIGN_BITS = 2,
    parameter logic [WIDTH-1:0] RESET_VEC  = '0,
    parameter logic [WIDTH-1:0] EXC_VEC    = WIDTH'('h80),
    parameter int               RAS_DEPTH  = 4
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Stall,
    input  logic             BranchTaken,
    input  logic [WIDTH-1:0] BranchTarget,
    input  logic             Jump,
    input  logic [WIDTH-1:0] JumpTarget,
    input  logic             Call,
    input  logic             Return,
    input  logic             Exception,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PCAddResult,
    output logic             Valid,
    output logic             Misaligned,
    output logic             RasEmpty,
    output logic             RasFull
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam logic [WIDTH-1:0] LOW = (WIDTH'(1) << ALIGN_BITS) - WIDTH'(1);
    typedef enum logic [1:0] {BOOT, RUN, EXC} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d, tgt;
    logic             valid_q, valid_d, mis_q, mis_d, pop;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [WIDTH-1:0] ras_d [RAS_DEPTH];
    logic [PW-1:0]    tp_q, tp_d, wr_idx;
    logic [CW-1:0]    cnt_q, cnt_d;
    assign PC          = pc_q;
    assign PCAddResult = pc_q + WIDTH'(INC);
    assign Valid       = valid_q;
    assign Misaligned  = mis_q;
    assign RasEmpty    = cnt_q == '0;
    assign RasFull     = cnt_q == CW'(RAS_DEPTH);
    assign pop         = Return && !RasEmpty;
    assign tgt         = BranchTaken ? BranchTarget : pop ? ras_q[tp_q] : JumpTarget;
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        mis_d   = 1'b0;
        ras_d   = ras_q;
        tp_d    = tp_q;
        cnt_d   = cnt_q;
        wr_idx  = pop ? tp_q : tp_q + 1'b1;
        case (state_q)
            BOOT, EXC: begin
                state_d = RUN;
                valid_d = 1'b1;
            end
            RUN: begin
                if (Exception) begin
                    state_d = EXC;
                    pc_d    = EXC_VEC;
                    valid_d = 1'b0;
                end else if (!Stall) begin
                    pc_d  = (BranchTaken || Jump) ? tgt & ~LOW : PCAddResult;
                    mis_d = (BranchTaken || Jump) && |(tgt & LOW);
                    // RAS moves only when the jump itself is the taken redirect
                    if (!BranchTaken && Jump) begin
                        if (pop) begin
                            tp_d  = tp_q - 1'b1;
                            cnt_d = cnt_q - 1'b1;
                        end
                        // Call after pop reuses the popped slot; a full stack overwrites its oldest entry
                        if (Call) begin
                            ras_d[wr_idx] = PCAddResult;
                            tp_d          = wr_idx;
                            cnt_d         = (pop || RasFull) ? cnt_q : cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = BOOT;
        endcase
    end
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_VEC;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            ras_q   <= '{default: '0};
            tp_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
            ras_q   <= ras_d;
            tp_q    <= tp_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
